// File: rtl/dmem_resp_pkg.sv
// Shared encodings for the data-memory responder: funct3 codes, FSM states, memory opcodes, request payload.
package dmem_resp_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  func3;
   } req_t;

   // Unsigned sizes are load-only; 011/110/111 are never legal.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b0;
         F3_BU, F3_HU:     return we;
         default:          return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables; contents are not reset.
module dmem_array
   import dmem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_idx,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: IDLE/BUSY/RESP handshake, byte-lane steering and load extension.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of truncating.
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_req_ready, r_resp_valid;
   req_t             r_req, w_req_in, w_req;
   logic             w_accept;

   logic        w_err, w_mem_en, w_unused;
   logic [1:0]  w_lane;
   logic [3:0]  w_be, w_we_be;
   logic [31:0] w_wdata_lane, w_ram_q;

   logic        r_rsp_err, r_rsp_we;
   logic [1:0]  r_rsp_lane;
   logic [2:0]  r_rsp_f3;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_rdata_ext;

   assign w_req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, func3: req_func3};
   assign w_accept = req_valid && (r_state == ST_IDLE);

   // With zero wait states the memory op happens on the accept edge, so use the live request.
   assign w_req    = (r_state == ST_IDLE) ? w_req_in : r_req;
   assign w_unused = ^w_req.addr[31:AW+2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_req_ready  <= (w_state_nxt == ST_IDLE);
         r_resp_valid <= (w_state_nxt == ST_RESP);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_BUSY;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) w_state_nxt = ST_RESP;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_req <= '0;
      else if (w_accept) r_req <= w_req_in;
   end

   // Lane selection, byte enables and store-data replication.
   always_comb begin
      w_err        = f3_illegal(w_req.we, w_req.func3);
      w_lane       = w_req.addr[1:0];
      w_be         = 4'b1111;
      w_wdata_lane = w_req.wdata;
      case (w_req.func3[1:0])
         2'b00: begin
            w_be         = 4'b0001 << w_lane;
            w_wdata_lane = {4{w_req.wdata[7:0]}};
         end
         2'b01: begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (w_req.addr[0]) w_err = 1'b1;
`else
            w_lane[0] = 1'b0;
`endif
            w_be         = 4'b0011 << w_lane;
            w_wdata_lane = {2{w_req.wdata[15:0]}};
         end
         default: begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (w_req.addr[1:0] != 2'b00) w_err = 1'b1;
`else
            w_lane = 2'b00;
`endif
         end
      endcase
   end

   // Gate with reset so an aborted access never touches the array.
   assign w_mem_en = rst && (w_state_nxt == ST_RESP);
   assign w_we_be  = (w_req.we && !w_err) ? w_be : 4'b0000;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .i_en    (w_mem_en),
      .i_be    (w_we_be),
      .i_idx   (w_req.addr[AW+1:2]),
      .i_wdata (w_wdata_lane),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rsp_err  <= 1'b0;
         r_rsp_we   <= 1'b0;
         r_rsp_lane <= 2'b00;
         r_rsp_f3   <= 3'b000;
      end else if (w_mem_en) begin
         r_rsp_err  <= w_err;
         r_rsp_we   <= w_req.we;
         r_rsp_lane <= w_lane;
         r_rsp_f3   <= w_req.func3;
      end
   end

   always_comb begin
      case (r_rsp_lane)
         2'd0:    w_byte = w_ram_q[7:0];
         2'd1:    w_byte = w_ram_q[15:8];
         2'd2:    w_byte = w_ram_q[23:16];
         default: w_byte = w_ram_q[31:24];
      endcase
      w_half = r_rsp_lane[1] ? w_ram_q[31:16] : w_ram_q[15:0];
      case (r_rsp_f3)
         F3_B:    w_rdata_ext = {{24{w_byte[7]}}, w_byte};
         F3_BU:   w_rdata_ext = {24'b0, w_byte};
         F3_H:    w_rdata_ext = {{16{w_half[15]}}, w_half};
         F3_HU:   w_rdata_ext = {16'b0, w_half};
         default: w_rdata_ext = w_ram_q;
      endcase
      if (!r_resp_valid || r_rsp_err || r_rsp_we) w_rdata_ext = '0;
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_valid && r_rsp_err;
   assign resp_rdata = w_rdata_ext;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp with 0, 1 and 3 wait states; expected responses are queued at issue and popped on resp_valid.
module tb_dmem_resp;

   localparam int unsigned DEPTH = 1024;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_we    [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [2:0]  req_func3 [3];
   logic        resp_valid[3];
   logic [31:0] resp_rdata[3];
   logic        resp_err  [3];

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_func3(req_func3[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut_w1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_func3(req_func3[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (
      .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_func3(req_func3[2]),
      .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

   function automatic int waits_of(input int s);
      return (s == 0) ? 0 : (s == 1) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input int s, input string tag);
      check({tag, "_ready"}, 32'(req_ready[s]), 32'd1);
      check({tag, "_valid"}, 32'(resp_valid[s]), 32'd0);
      check({tag, "_rdata"}, resp_rdata[s], 32'd0);
      check({tag, "_err"},   32'(resp_err[s]), 32'd0);
   endtask

   // One request on instance s; expectations go to the scoreboard, compared when resp_valid rises.
   task automatic access(input int s, input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic [31:0] exp_rd, input logic exp_err);
      int   k;
      exp_t e;
      sb_q.push_back('{rdata: exp_rd, err: exp_err});
      @(negedge clk);
      check({tag, "_ready_in"}, 32'(req_ready[s]), 32'd1);
      req_valid[s] = 1'b1;
      req_we[s]    = we;
      req_addr[s]  = addr;
      req_wdata[s] = wd;
      req_func3[s] = f3;
      @(posedge clk);
      @(negedge clk);
      req_valid[s] = 1'b0;
      req_we[s]    = 1'($urandom);
      req_addr[s]  = $urandom;
      req_wdata[s] = $urandom;
      req_func3[s] = 3'($urandom);
      k = 0;
      while (!resp_valid[s] && k < 32) begin
         check({tag, "_busy_ready"}, 32'(req_ready[s]), 32'd0);
         check({tag, "_busy_rdata"}, resp_rdata[s], 32'd0);
         @(negedge clk);
         k++;
      end
      check({tag, "_resp_seen"}, 32'(resp_valid[s]), 32'd1);
      check({tag, "_latency"}, 32'(k), 32'(waits_of(s)));
      e = sb_q.pop_front();
      check({tag, "_rdata"}, resp_rdata[s], e.rdata);
      check({tag, "_err"},   32'(resp_err[s]), 32'(e.err));
      check({tag, "_resp_ready"}, 32'(req_ready[s]), 32'd0);
      @(negedge clk);
      check_idle_outputs(s, {tag, "_after"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_func3[i] = '0;
      end
      repeat (3) @(negedge clk);
      check_idle_outputs(0, "reset_w0");
      check_idle_outputs(1, "reset_w1");
      check_idle_outputs(2, "reset_w3");
      rst = 1'b1;

      // One wait state: basic store/load and lane extension.
      access(1, "sw_10",    1'b1, 32'h10, 32'hDEADBEEF, LW,  32'h0,        1'b0);
      access(1, "lw_10",    1'b0, 32'h10, 32'h0,        LW,  32'hDEADBEEF, 1'b0);
      access(1, "lb_13",    1'b0, 32'h13, 32'h0,        LB,  32'hFFFFFFDE, 1'b0);
      access(1, "lbu_13",   1'b0, 32'h13, 32'h0,        LBU, 32'h000000DE, 1'b0);
      access(1, "lh_12",    1'b0, 32'h12, 32'h0,        LH,  32'hFFFFDEAD, 1'b0);
      access(1, "lhu_10",   1'b0, 32'h10, 32'h0,        LHU, 32'h0000BEEF, 1'b0);
      access(1, "sb_11",    1'b1, 32'h11, 32'h55,       LB,  32'h0,        1'b0);
      access(1, "lw_10b",   1'b0, 32'h10, 32'h0,        LW,  32'hDEAD55EF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
      access(1, "lw_12mis", 1'b0, 32'h12, 32'h0,        LW,  32'h0,        1'b1);
`else
      access(1, "lw_12mis", 1'b0, 32'h12, 32'h0,        LW,  32'hDEAD55EF, 1'b0);
`endif
      access(1, "f3_011",   1'b0, 32'h10, 32'h0,        3'b011, 32'h0,     1'b1);
      access(1, "sbu_err",  1'b1, 32'h10, 32'h0,        LBU, 32'h0,        1'b1);
      access(1, "lw_10c",   1'b0, 32'h10, 32'h0,        LW,  32'hDEAD55EF, 1'b0);
      access(1, "sw_wrap",  1'b1, 32'h10 + 4*DEPTH, 32'h12345678, LW, 32'h0, 1'b0);
      access(1, "lw_wrap",  1'b0, 32'h10, 32'h0,        LW,  32'h12345678, 1'b0);

      access(1, "sw_14",    1'b1, 32'h14, 32'h11223344, LW,  32'h0,        1'b0);
      access(1, "sh_16",    1'b1, 32'h16, 32'h0000CAFE, LH,  32'h0,        1'b0);
      access(1, "lw_14",    1'b0, 32'h14, 32'h0,        LW,  32'hCAFE3344, 1'b0);
      access(1, "lb_14",    1'b0, 32'h14, 32'h0,        LB,  32'h00000044, 1'b0);
      access(1, "lb_17",    1'b0, 32'h17, 32'h0,        LB,  32'hFFFFFFCA, 1'b0);
      access(1, "lh_16",    1'b0, 32'h16, 32'h0,        LH,  32'hFFFFCAFE, 1'b0);
      access(1, "lw_hi",    1'b0, 32'hFFFF0014, 32'h0,  LW,  32'hCAFE3344, 1'b0);
      access(1, "f3_110",   1'b0, 32'h14, 32'h0,        3'b110, 32'h0,     1'b1);
      access(1, "shu_err",  1'b1, 32'h14, 32'hFFFFFFFF, LHU, 32'h0,        1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
      access(1, "lh_15mis", 1'b0, 32'h15, 32'h0,        LH,  32'h0,        1'b1);
      access(1, "sh_17mis", 1'b1, 32'h17, 32'h7777,     LH,  32'h0,        1'b1);
      access(1, "lw_14b",   1'b0, 32'h14, 32'h0,        LW,  32'hCAFE3344, 1'b0);
`else
      access(1, "lh_15mis", 1'b0, 32'h15, 32'h0,        LH,  32'h00003344, 1'b0);
      access(1, "sh_17mis", 1'b1, 32'h17, 32'h7777,     LH,  32'h0,        1'b0);
      access(1, "lw_14b",   1'b0, 32'h14, 32'h0,        LW,  32'h77773344, 1'b0);
`endif

      // Zero wait states: memory op on the accept edge.
      access(0, "w0_sw",    1'b1, 32'h8, 32'hA5A5A5A5,  LW,  32'h0,        1'b0);
      access(0, "w0_sb",    1'b1, 32'hB, 32'h3C,        LB,  32'h0,        1'b0);
      access(0, "w0_lw",    1'b0, 32'h8, 32'h0,         LW,  32'h3CA5A5A5, 1'b0);
      access(0, "w0_lhu",   1'b0, 32'hA, 32'h0,         LHU, 32'h00003CA5, 1'b0);
      access(0, "w0_lb",    1'b0, 32'hB, 32'h0,         LB,  32'h0000003C, 1'b0);

      // Three wait states, then a reset mid-store must leave memory untouched.
      access(2, "w3_sw",    1'b1, 32'h20, 32'h01020304, LW,  32'h0,        1'b0);
      access(2, "w3_lw",    1'b0, 32'h20, 32'h0,        LW,  32'h01020304, 1'b0);
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
      req_wdata[2] = 32'hFFFFFFFF; req_func3[2] = LW;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      check("abort_busy_ready", 32'(req_ready[2]), 32'd0);
      rst = 1'b0;
      #1;
      check_idle_outputs(2, "abort_in_reset");
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid[2]) seen = 1'b1;
      end
      check("abort_no_resp", 32'(seen), 32'd0);
      access(2, "w3_lw_old", 1'b0, 32'h20, 32'h0,       LW,  32'h01020304, 1'b0);
      access(2, "w3_lbu",    1'b0, 32'h21, 32'h0,       LBU, 32'h00000003, 1'b0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words in the array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the wait states inserted between accept and response (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate an access request from the MEM stage.
REQ-006 req_ready  output  1  SHALL indicate the responder can accept a request.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_addr  input  32  SHALL be the byte address (the ALU result).
REQ-009 req_wdata  input  32  SHALL be the store data (the rs_2 value), taken from the low lanes.
REQ-010 req_func3  input  3  SHALL be the RISC-V funct3 access size and sign code.
REQ-011 resp_valid  output  1  SHALL pulse for one cycle when an access completes.
REQ-012 resp_rdata  output  32  SHALL carry the extended load data while resp_valid is high.
REQ-013 resp_err  output  1  SHALL flag a rejected access while resp_valid is high.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and RESP, with req_ready = (state == IDLE).
REQ-015 A request SHALL be accepted on a posedge with req_valid && req_ready, and the block SHALL capture we, addr, wdata and func3 on that edge.
REQ-016 On accept, the FSM SHALL go to BUSY with the counter loaded to WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES = 0.
REQ-017 BUSY SHALL decrement the counter each cycle and go to RESP on the edge at which the counter is 0.
REQ-018 resp_valid SHALL be high only in RESP, first high after edge E+WAIT_CYCLES (E = accepting edge), for exactly one cycle.
REQ-019 RESP SHALL always return to IDLE on the next edge, with no response backpressure; a new request is accepted no earlier than the edge after the RESP cycle.
REQ-020 Store writes and load reads SHALL both take effect on the edge entering RESP; a load issued after a store to the same word SHALL return the new data.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo the array size.
REQ-022 Loads SHALL use lane addr[1:0]: LB 000 sign-extends the byte, LH 001 sign-extends the half, LW 010 returns the word, LBU 100 and LHU 101 zero-extend.
REQ-023 Stores SHALL use the same lane selection: SB 000 writes one byte, SH 001 writes a halfword, SW 010 writes the full word, and other lanes SHALL be preserved.
REQ-024 For a store with func3 100/101, or any access with func3 011/110/111, the block SHALL set resp_err=1, write nothing and return resp_rdata=0.
REQ-025 For stores, resp_rdata SHALL be 0.
REQ-026 Outside RESP, resp_rdata and resp_err SHALL be 0.

Reset
REQ-027 While rst=0: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-028 An assertion of rst during BUSY or RESP SHALL abort the access, and a pending store SHALL NOT be written.
REQ-029 Array contents SHALL NOT be reset.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL produce resp_err=1, no write and rdata 0.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, misaligned low address bits SHALL be truncated to the access size (half: addr[0]=0, word: addr[1:0]=0), and the access SHALL complete with resp_err=0.

Structure
REQ-032 The shared package SHALL hold the funct3 load/store encodings, the FSM state encoding, and the load/store opcodes 0000011 and 0100011.
REQ-033 A sub-module dmem_array SHALL implement the synchronous word RAM with 4-bit byte write enables; dmem_resp SHALL hold the FSM, lane steering and extension.

Verification
REQ-034 W=1: SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> each resp_valid one cycle at E+1; LW rdata=0xDEADBEEF, err=0.
REQ-035 After REQ-034: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-036 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
REQ-037 LW 0x12 with the macro defined -> err=1, rdata=0; without it -> rdata=word@0x10, err=0.
REQ-038 func3=011 -> err=1; SW to addr 0x10+4*DEPTH_WORDS -> overwrites word 0x10 (wrap).
REQ-039 W=3, SW accepted and rst pulsed low in BUSY -> no resp_valid, req_ready=1, LW of the same address returns the old data.
